// File: rtl/gift_word_loader.sv
// Word-bus adapter for a GIFT core: packs 32-bit key/data words into 128-bit blocks,
// launches the core, waits out its busy period and streams the 128-bit result back as words.
`timescale 1ns/1ps
module gift_word_loader #(
  parameter int ARM_MAX = 2
) (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inWordWr,
  input  logic         inWordSel,
  input  logic [31:0]  inWordData,
  output logic         outInRdy,
  output logic         outWordValid,
  output logic [31:0]  outWordData,
  input  logic         inWordRdy,
  output logic         outCoreKeyWr,
  output logic         outCoreDataWr,
  output logic [127:0] outCoreKey,
  output logic [127:0] outCoreData,
  input  logic [127:0] inCoreData,
  input  logic         inCoreBusy,
  output logic [2:0]   dbg_state
);

  localparam int ARM_W = (ARM_MAX > 1) ? $clog2(ARM_MAX) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         key_cnt, data_cnt;
  logic               key_valid, key_valid_nxt;
  logic [ARM_W-1:0]   arm_cnt;
  logic [1:0]         out_idx;
  logic [127:0]       result;
  logic               in_idle, data_acc, key_acc, data_full_nxt;

  // Word bus: a word moves when inWordWr is high and the loader is ready for it.
  // Data words need outInRdy. Key words are also taken in IDLE while a full data block
  // is parked waiting for the key, otherwise that block could never launch.
  assign in_idle  = (state == S_IDLE);
  assign outInRdy = in_idle && (data_cnt < 3'd4);
  assign data_acc = inWordWr && !inWordSel && outInRdy;
  assign key_acc  = inWordWr && inWordSel && in_idle;

  // Launch decision looks at the values this edge will produce, so the LAUNCH
  // cycle immediately follows the word that completes the key/data pair.
  assign key_valid_nxt = key_acc ? (key_cnt == 3'd3) : key_valid;
  assign data_full_nxt = (data_cnt == 3'd4) || (data_acc && (data_cnt == 3'd3));

  assign outCoreKeyWr  = (state == S_LAUNCH);
  assign outCoreDataWr = (state == S_LAUNCH);
  assign outWordValid  = (state == S_DRAIN);
  assign outWordData   = outWordValid ? result[{~out_idx, 5'b0} +: 32] : 32'd0;
  assign dbg_state     = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (data_full_nxt && key_valid_nxt && !inCoreBusy) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_ARM;
      S_ARM:    if (inCoreBusy || (arm_cnt == ARM_LAST)) state_nxt = S_WAIT;
      S_WAIT:   if (!inCoreBusy) state_nxt = S_DRAIN;
      S_DRAIN:  if (inWordRdy && (out_idx == 2'd3)) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state       <= S_IDLE;
      key_cnt     <= 3'd0;
      data_cnt    <= 3'd0;
      key_valid   <= 1'b0;
      arm_cnt     <= '0;
      out_idx     <= 2'd0;
      outCoreKey  <= '0;
      outCoreData <= '0;
      result      <= '0;
    end else begin
      state <= state_nxt;
      if (key_acc) begin
        outCoreKey[{~key_cnt[1:0], 5'b0} +: 32] <= inWordData;
        key_cnt   <= (key_cnt == 3'd3) ? 3'd0 : key_cnt + 3'd1;
        key_valid <= key_valid_nxt;
      end
      if (data_acc) begin
        outCoreData[{~data_cnt[1:0], 5'b0} +: 32] <= inWordData;
        data_cnt <= data_cnt + 3'd1;
      end
      case (state)
        S_LAUNCH: begin
          data_cnt <= 3'd0;
          arm_cnt  <= '0;
        end
        S_ARM:   arm_cnt <= arm_cnt + 1'b1;
        S_WAIT: begin
          if (!inCoreBusy) begin
            result  <= inCoreData;
            out_idx <= 2'd0;
          end
        end
        S_DRAIN: if (inWordRdy) out_idx <= out_idx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
